// File: rtl/pc_branch_unit_if.sv
// Fetch-side bundle of the PC/branch unit: decision inputs from the branch gate,
// fetch address and status outputs towards instruction memory.
interface pc_branch_unit_if;
    logic        Stall;
    logic        PCSrc;
    logic        Jump;
    logic [15:0] Imm16;
    logic [25:0] JumpIndex;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic        Valid;
    logic        Redirect;

    modport master (
        output Stall, PCSrc, Jump, Imm16, JumpIndex,
        input  PC, PCPlus4, Valid, Redirect
    );

    modport slave (
        input  Stall, PCSrc, Jump, Imm16, JumpIndex,
        output PC, PCPlus4, Valid, Redirect
    );
endinterface

// File: rtl/pc_branch_unit.sv
// Program-counter update unit: holds the fetch PC and selects sequential, branch or jump next PC.
// Optional MIPS delay slot behaviour is enabled by defining BRANCH_DELAY_SLOT_EN.
module pc_branch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst,
    pc_branch_unit_if.slave  bus
);

    localparam logic [1:0] ST_HOLD = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
`ifdef BRANCH_DELAY_SLOT_EN
    localparam logic [1:0] ST_DLY  = 2'b10;
`endif

    function automatic logic [31:0] branch_target(input logic [31:0] pc_plus4,
                                                  input logic [15:0] imm);
        return pc_plus4 + {{14{imm[15]}}, imm, 2'b00};
    endfunction

    function automatic logic [31:0] jump_target(input logic [31:0] pc_plus4,
                                                input logic [25:0] index);
        return {pc_plus4[31:28], index, 2'b00};
    endfunction

    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic        valid_q;
    logic        valid_d;
    logic        redirect_q;
    logic        redirect_d;
    logic [1:0]  state_q;
    logic [1:0]  state_d;
    logic [31:0] pc_plus4_s;
    logic [31:0] target_s;
    logic        take_s;
`ifdef BRANCH_DELAY_SLOT_EN
    logic [31:0] pending_q;
    logic [31:0] pending_d;
`endif

    assign pc_plus4_s = pc_q + 32'd4;

    // Target selection: jump outranks a taken branch
    always_comb begin
        take_s   = 1'b0;
        target_s = pc_plus4_s;
        if (bus.Jump) begin
            take_s   = 1'b1;
            target_s = jump_target(pc_plus4_s, bus.JumpIndex);
        end else if (bus.PCSrc) begin
            take_s   = 1'b1;
            target_s = branch_target(pc_plus4_s, bus.Imm16);
        end else begin
            take_s   = 1'b0;
            target_s = pc_plus4_s;
        end
    end

    // Next-state logic; a stall freezes everything and drops the sampled decision
    always_comb begin
        pc_d       = pc_q;
        valid_d    = valid_q;
        redirect_d = redirect_q;
        state_d    = state_q;
`ifdef BRANCH_DELAY_SLOT_EN
        pending_d  = pending_q;
`endif
        if (!bus.Stall) begin
            case (state_q)
                ST_HOLD: begin
                    valid_d    = 1'b1;
                    redirect_d = 1'b0;
                    state_d    = ST_RUN;
                end
                ST_RUN: begin
                    redirect_d = 1'b0;
                    if (valid_q && take_s) begin
`ifdef BRANCH_DELAY_SLOT_EN
                        pending_d = target_s;
                        pc_d      = pc_plus4_s;
                        state_d   = ST_DLY;
`else
                        pc_d       = target_s;
                        redirect_d = 1'b1;
`endif
                    end else begin
                        pc_d = pc_plus4_s;
                    end
                end
`ifdef BRANCH_DELAY_SLOT_EN
                // Delay slot retired: decision inputs are not looked at here
                ST_DLY: begin
                    pc_d       = pending_q;
                    redirect_d = 1'b1;
                    state_d    = ST_RUN;
                end
`endif
                default: begin
                    pc_d       = RESET_VECTOR;
                    valid_d    = 1'b0;
                    redirect_d = 1'b0;
                    state_d    = ST_HOLD;
                end
            endcase
        end else begin
            pc_d       = pc_q;
            valid_d    = valid_q;
            redirect_d = redirect_q;
            state_d    = state_q;
        end
    end

    // State registers with synchronous reset that overrides stall
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_VECTOR;
            valid_q    <= 1'b0;
            redirect_q <= 1'b0;
            state_q    <= ST_HOLD;
`ifdef BRANCH_DELAY_SLOT_EN
            pending_q  <= 32'h0000_0000;
`endif
        end else begin
            pc_q       <= pc_d;
            valid_q    <= valid_d;
            redirect_q <= redirect_d;
            state_q    <= state_d;
`ifdef BRANCH_DELAY_SLOT_EN
            pending_q  <= pending_d;
`endif
        end
    end

    assign bus.PC       = pc_q;
    assign bus.PCPlus4  = pc_plus4_s;
    assign bus.Valid    = valid_q;
    assign bus.Redirect = redirect_q;

endmodule
